// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRBS generator and checker.
// The generator and checker must agree on width and taps.
package lfsr_pkg;

    localparam int                     LFSR_WIDTH = 8;
    localparam logic [LFSR_WIDTH-1:0]  LFSR_TAPS  = 8'hB8;

    // Leaky-bucket loss detector: each mismatch adds BUCKET_INC, each match drains one.
    localparam int BUCKET_W   = 4;
    localparam int BUCKET_INC = 4;
    localparam int BUCKET_MAX = 15;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with a prediction output.
// load_en shifts in an external bit; adv_en shifts in the prediction (free-run).
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int                WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0]  TAPS  = LFSR_TAPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic             adv_en,
    input  logic             d_in,
    output logic [WIDTH-1:0] state,
    output logic             p
);

    assign p = ^(state & TAPS);

    always_ff @(posedge clk) begin
        if (!rst_n)       state <= '0;
        else if (load_en) state <= {state[WIDTH-2:0], d_in};
        else if (adv_en)  state <= {state[WIDTH-2:0], p};
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: HUNT loads state from the stream, VERIFY
// confirms the prediction, LOCKED free-runs and counts mismatches with hysteresis.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int                WIDTH       = LFSR_WIDTH,
    parameter logic [WIDTH-1:0]  TAPS        = LFSR_TAPS,
    parameter int                LOCK_COUNT  = 16,
    parameter int                LOSS_THRESH = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        bit_valid,
    input  logic        bit_in,
    input  logic        clr_err,
    output logic        locked,
    output logic [1:0]  fsm_state,
    output logic        bit_err,
    output logic [15:0] err_count
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);

    fsm_state_e          state_q, state_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [BUCKET_W-1:0] bucket_q, bucket_d, bucket_sat;
    logic [BUCKET_W:0]   bucket_up;
    logic [15:0]         err_q, err_d;
    logic                bit_err_q, bit_err_d;

    logic [WIDTH-1:0]    s, s_shift;
    logic                p, beat, match;

    assign beat      = ena & bit_valid;
    assign match     = (bit_in == p);
    assign s_shift   = {s[WIDTH-2:0], bit_in};
    assign bucket_up = {1'b0, bucket_q} + (BUCKET_W+1)'(BUCKET_INC);
    assign bucket_sat = (bucket_up > (BUCKET_W+1)'(BUCKET_MAX)) ? BUCKET_W'(BUCKET_MAX)
                                                               : bucket_up[BUCKET_W-1:0];

    // Once locked the state free-runs on its own prediction so line errors stay out of it.
    lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (beat & (state_q != LOCKED)),
        .adv_en  (beat & (state_q == LOCKED)),
        .d_in    (bit_in),
        .state   (s),
        .p       (p)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            fill_q    <= '0;
            run_q     <= '0;
            bucket_q  <= '0;
            err_q     <= '0;
            bit_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            run_q     <= run_d;
            bucket_q  <= bucket_d;
            err_q     <= err_d;
            bit_err_q <= bit_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        run_d     = run_q;
        bucket_d  = bucket_q;
        err_d     = err_q;
        bit_err_d = 1'b0;
        if (beat) begin
            unique case (state_q)
                HUNT: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_d == FILL_W'(WIDTH)) begin
                        fill_d = '0;
                        // All-zero is the lockup state; keep hunting.
                        if (s_shift != '0) begin
                            state_d = VERIFY;
                            run_d   = '0;
                        end
                    end
                end
                VERIFY: begin
                    if (match) begin
                        run_d = run_q + 1'b1;
                        if (run_d == RUN_W'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            run_d    = '0;
                            bucket_d = '0;
                        end
                    end else begin
                        state_d = HUNT;
                        fill_d  = '0;
                        run_d   = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        bucket_d = (bucket_q == '0) ? '0 : bucket_q - 1'b1;
                    end else begin
                        bit_err_d = 1'b1;
                        bucket_d  = bucket_sat;
                        if (err_q != 16'hFFFF) err_d = err_q + 1'b1;
                    end
                    if (bucket_d >= BUCKET_W'(LOSS_THRESH)) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (ena && clr_err) err_d = '0;
    end

    always_comb begin
        locked    = (state_q == LOCKED);
        fsm_state = state_q;
        bit_err   = bit_err_q;
        err_count = err_q;
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed PRBS stimulus with hand-derived expectations pushed to a scoreboard;
// a negedge monitor pops and compares each registered response.
module tb_lfsr_checker;

    logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, clr_err = 1'b0;
    logic        locked, bit_err;
    logic [1:0]  fsm_state;
    logic [15:0] err_count;

    typedef struct {
        int          stamp;
        string       tag;
        logic [1:0]  st;
        logic        be;
        logic [15:0] ec;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    int         edge_cnt    = 0;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] g = 8'h01;

    lfsr_checker #(.WIDTH(8), .TAPS(8'hB8), .LOCK_COUNT(16), .LOSS_THRESH(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .clr_err   (clr_err),
        .locked    (locked),
        .fsm_state (fsm_state),
        .bit_err   (bit_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].stamp <= edge_cnt) begin
            cur = sb.pop_front();
            vectors++;
            if (locked !== (cur.st == 2'd2) || fsm_state !== cur.st ||
                bit_err !== cur.be || err_count !== cur.ec) begin
                miscompares++;
                $display("FAIL %s: got locked=%b state=%0d bit_err=%b err=%0d, want locked=%b state=%0d bit_err=%b err=%0d",
                         cur.tag, locked, fsm_state, bit_err, err_count,
                         (cur.st == 2'd2), cur.st, cur.be, cur.ec);
            end
        end
    end

    // Apply one cycle of inputs and queue the response expected after its edge.
    task automatic drive(input string tag, input logic e, input logic v, input logic b,
                         input logic c, input logic r, input logic [1:0] st,
                         input logic be, input logic [15:0] ec);
        exp_t x;
        ena = e; bit_valid = v; bit_in = b; clr_err = c; rst_n = r;
        x.stamp = edge_cnt + 1;
        x.tag   = tag;
        x.st    = st;
        x.be    = be;
        x.ec    = ec;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Next generator bit (optionally flipped on the line) as one beat.
    task automatic beat(input string tag, input logic flip, input logic c,
                        input logic [1:0] st, input logic be, input logic [15:0] ec);
        logic nb;
        nb = ^(g & 8'hB8);
        g  = {g[6:0], nb};
        drive(tag, 1'b1, 1'b1, nb ^ flip, c, 1'b1, st, be, ec);
    endtask

    // Beats offered during reset must be discarded.
    task automatic do_reset(input string tag);
        drive(tag, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
        drive(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
        g = 8'h01;
    endtask

    initial begin
        logic        fl;
        logic [1:0]  st;
        logic [15:0] ec;

        @(posedge clk);
        #1;

        do_reset("reset");
        for (int n = 1; n <= 1000; n++)
            beat($sformatf("clean beat %0d", n), 1'b0, 1'b0,
                 n < 8 ? 2'd0 : n < 24 ? 2'd1 : 2'd2, 1'b0, 16'd0);

        // Single flip at 100, burst at 200-202, relock 24 beats later.
        do_reset("reset p2");
        for (int n = 1; n <= 260; n++) begin
            fl = (n == 100) || (n >= 200 && n <= 202);
            st = n < 8 ? 2'd0 : n < 24 ? 2'd1 : n < 202 ? 2'd2 :
                 n < 210 ? 2'd0 : n < 226 ? 2'd1 : 2'd2;
            ec = n < 100 ? 16'd0 : n < 200 ? 16'd1 : n <= 202 ? 16'(n - 198) : 16'd4;
            beat($sformatf("errs beat %0d", n), fl, 1'b0, st, fl, ec);
            if (n == 100) begin
                drive("freeze locked", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 16'd1);
                drive("idle locked",   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 16'd1);
            end
            if (n == 205) begin
                drive("freeze hunt",     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 16'd4);
                drive("freeze clr_err",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 16'd4);
                drive("idle hunt",       1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 16'd4);
            end
        end

        do_reset("reset p3");
        for (int n = 1; n <= 64; n++)
            drive($sformatf("zeros beat %0d", n), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);

        // Flip in VERIFY, then locked errors with clr_err coincident at 51.
        do_reset("reset p4");
        for (int n = 1; n <= 54; n++) begin
            fl = (n == 15) || (n == 45) || (n == 51) || (n == 53);
            st = n < 8 ? 2'd0 : n < 15 ? 2'd1 : n < 23 ? 2'd0 : n < 39 ? 2'd1 : 2'd2;
            ec = n < 45 ? 16'd0 : n < 51 ? 16'd1 : n < 53 ? 16'd0 : 16'd1;
            beat($sformatf("verify beat %0d", n), fl, (n == 51), st, fl && (n != 15), ec);
        end
        drive("clr only",        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 16'd0);
        beat("pre-reset err", 1'b1, 1'b0, 2'd2, 1'b1, 16'd1);
        drive("reset in locked", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
        drive("reset hold",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
        drive("after reset",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 16'd0);

        repeat (2) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard drain: %0d responses unchecked, want 0", sb.size());
            miscompares += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial PRBS checker that receives the bit stream produced by the team's Fibonacci LFSR generator. It self-synchronises by loading its state from received bits, then predicts each following bit and counts mismatches. It declares and drops lock with hysteresis. It sits inside the Tiny Tapeout user wrapper next to the generator, so one die can self-test in loopback or check an external stream.

## Interface
Parameters:
- WIDTH, 8: LFSR length in bits.
- TAPS, 8'hB8: feedback mask (x^8+x^6+x^5+x^4+1). Must equal the generator's mask.
- LOCK_COUNT, 16: consecutive correct predictions required to enter LOCKED.
- LOSS_THRESH, 12: leaky-bucket level at which lock is dropped.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- ena  in  1  design enable; when low, all inputs are ignored and all state holds.
- bit_valid  in  1  bit_in carries a stream bit this cycle.
- bit_in  in  1  received stream bit.
- clr_err  in  1  single-cycle request to clear err_count.
- locked  out  1  high in LOCKED.
- fsm_state  out  2  0=HUNT, 1=VERIFY, 2=LOCKED.
- bit_err  out  1  one-cycle pulse per mismatch while LOCKED.
- err_count  out  16  mismatches counted while LOCKED; saturates at 16'hFFFF.

## Operation
- A beat is a cycle with ena=1 and bit_valid=1. Nothing advances on other cycles.
- Prediction: p = ^(s & TAPS). The state s shifts as s <= {s[WIDTH-2:0], b}.
- HUNT:
  - Each beat sets s <= {s, bit_in} and fill++.
  - When fill reaches WIDTH: go to VERIFY if s≠0. If s=0 (lockup state), clear fill and stay in HUNT.
- VERIFY:
  - Each beat compares bit_in with p and shifts in bit_in.
  - On a match, run++. When run reaches LOCK_COUNT, go to LOCKED and clear the bucket.
  - On a mismatch, go to HUNT and clear fill and run.
  - err_count is untouched in HUNT and VERIFY.
- LOCKED:
  - s shifts in p, not bit_in, so an error does not propagate into the state.
  - On a mismatch: bit_err pulses, err_count++ (saturating), and bucket = min(bucket+4, 15).
  - On a match: bucket = max(bucket−1, 0).
  - When the updated bucket is ≥ LOSS_THRESH, go to HUNT with fill=0.
- clr_err: sets err_count to 0 on the next edge. It has priority over a coincident increment. That error is not counted, but bit_err still pulses.

## Timing
- All outputs are registered and update on the edge that consumes the beat.
- Response latency is 1 cycle from the beat.
- Reset values: locked=0, fsm_state=0, bit_err=0, err_count=0. Internally s=0, fill=0, run=0, bucket=0.
- Minimum time to lock from reset is WIDTH+LOCK_COUNT beats (24 by default). locked rises in the cycle after the 24th beat.
- Lock drop: locked falls in the cycle after the beat that reaches the threshold. With defaults, 3 back-to-back mismatches (4→8→12) drop lock.
- A reset asserted mid-operation takes effect at the next edge from any state. Beats presented during that cycle are discarded.
- Lowering ena mid-stream freezes everything, and bit_err is 0 while frozen. Raising ena again resumes with no loss.

## Structure
- Package lfsr_pkg:
  - LFSR_WIDTH and LFSR_TAPS, shared with the generator.
  - The fsm_state enum (HUNT/VERIFY/LOCKED).
  - The bucket increment (4) and maximum (15) constants.
- Sub-module lfsr_core:
  - Holds the WIDTH-bit state register with load-shift and advance enables.
  - Outputs the prediction p.
  - Reused by the generator.
- The checker itself contains the FSM, the fill/run/bucket counters and err_count.

## Test plan
- Clean stream: generator seeded 8'h01, continuous beats → fsm_state goes 0→1 at beat 8 and locked=1 after beat 24. err_count stays 0 over 1000 beats.
- Single flip at beat 100, while locked → one bit_err pulse and err_count=1. locked stays 1 and the bucket decays back to 0 after 4 matches.
- Three consecutive flips at beats 200–202 → err_count +3 and locked falls after beat 202. After a further 24 clean beats, locked=1 again.
- All-zero input for 64 beats → fsm_state stays 0 and locked=0. bit_err never pulses and err_count=0.
- Flip during VERIFY (beat 15) → return to HUNT. Lock arrives 24 beats after the restart, and err_count remains 0.
- clr_err coincident with a mismatch, and rst_n=0 mid-LOCKED:
  - Coincident case: err_count=0 and bit_err=1.
  - Reset case: all outputs equal their reset values in the next cycle.
